// File: rtl/writeback_queue.sv
// writeback_queue: buffers register-file writeback requests and drains one
// per cycle into the register file's write port. Dual requests (MUL/DIV)
// write both result halves in one cycle. Two combinational scoreboard ports
// report whether a register still has a write pending, either queued or
// currently being presented to the register file.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_dual,
  input  logic [3:0]    in_reg1,
  input  logic [3:0]    in_reg2,
  input  logic [15:0]   in_data1,
  input  logic [15:0]   in_data2,

  input  logic          stall,

  output logic [1:0]    RegWrite,
  output logic [3:0]    WriteReg1,
  output logic [3:0]    WriteReg2,
  output logic [15:0]   WriteData1,
  output logic [15:0]   WriteData2,

  input  logic [3:0]    chk_reg1,
  input  logic [3:0]    chk_reg2,
  output logic          chk_busy1,
  output logic          chk_busy2,

  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  // DEPTH is a power of two, so the pointers wrap naturally at PW bits.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue state. Entries live in flops rather than block RAM because the
  // scoreboard must compare every entry against the lookup registers at once.
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          dual_mem  [DEPTH];
  logic [3:0]    reg1_mem  [DEPTH];
  logic [3:0]    reg2_mem  [DEPTH];
  logic [15:0]   data1_mem [DEPTH];
  logic [15:0]   data2_mem [DEPTH];

  // Registered register-file write port.
  logic [1:0]    regwrite_reg;
  logic [3:0]    wreg1_reg;
  logic [3:0]    wreg2_reg;
  logic [15:0]   wdata1_reg;
  logic [15:0]   wdata2_reg;

  logic push;
  logic pop;

  logic          head_dual;
  logic [3:0]    head_reg1;
  logic [3:0]    head_reg2;
  logic [15:0]   head_data1;
  logic [15:0]   head_data2;
  logic          head_collapse;

  // Status is derived from the explicit count, which keeps full and empty
  // distinct when the pointers are equal after a wrap.
  assign full     = (count_reg == DEPTH_C);
  assign empty    = (count_reg == '0);
  assign in_ready = !full;
  assign count    = count_reg;

  // A full queue refuses a push even when a pop frees a slot in the same
  // cycle; in_ready depends on state only, never on stall.
  assign push = in_valid && !full;
  assign pop  = !empty && !stall;

  assign head_dual  = dual_mem[rd_ptr_reg];
  assign head_reg1  = reg1_mem[rd_ptr_reg];
  assign head_reg2  = reg2_mem[rd_ptr_reg];
  assign head_data1 = data1_mem[rd_ptr_reg];
  assign head_data2 = data2_mem[rd_ptr_reg];

  // A dual write to the same register cannot be done as two writes; it
  // degrades to a single write of the second result.
  assign head_collapse = head_dual && (head_reg1 == head_reg2);

  // Pointer and occupancy update; reset discards any push/pop that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage: cleared on reset so nothing downstream ever sees X,
  // written at the tail on an accepted push.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dual_mem[i]  <= 1'b0;
        reg1_mem[i]  <= '0;
        reg2_mem[i]  <= '0;
        data1_mem[i] <= '0;
        data2_mem[i] <= '0;
      end
    end else if (push) begin
      dual_mem[wr_ptr_reg]  <= in_dual;
      reg1_mem[wr_ptr_reg]  <= in_reg1;
      reg2_mem[wr_ptr_reg]  <= in_reg2;
      data1_mem[wr_ptr_reg] <= in_data1;
      data2_mem[wr_ptr_reg] <= in_data2;
    end
  end

  // Write-port register: loads the head on a pop and pulses RegWrite for one
  // cycle; register/data fields hold between writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite_reg <= 2'd0;
      wreg1_reg    <= '0;
      wreg2_reg    <= '0;
      wdata1_reg   <= '0;
      wdata2_reg   <= '0;
    end else if (pop) begin
      regwrite_reg <= (head_dual && !head_collapse) ? 2'd2 : 2'd1;
      wreg1_reg    <= head_reg1;
      wreg2_reg    <= head_reg2;
      wdata1_reg   <= head_collapse ? head_data2 : head_data1;
      wdata2_reg   <= head_data2;
    end else begin
      regwrite_reg <= 2'd0;
    end
  end

  assign RegWrite   = regwrite_reg;
  assign WriteReg1  = wreg1_reg;
  assign WriteReg2  = wreg2_reg;
  assign WriteData1 = wdata1_reg;
  assign WriteData2 = wdata2_reg;

  // Scoreboard: an entry is live when its distance from the read pointer is
  // below the occupancy. reg2 only counts for dual entries.
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_reg;
    assign entry_valid[gi] = (CW'(offset) < count_reg);
    assign hit1[gi] = entry_valid[gi] &&
                      ((reg1_mem[gi] == chk_reg1) ||
                       (dual_mem[gi] && (reg2_mem[gi] == chk_reg1)));
    assign hit2[gi] = entry_valid[gi] &&
                      ((reg1_mem[gi] == chk_reg2) ||
                       (dual_mem[gi] && (reg2_mem[gi] == chk_reg2)));
  end

  // The write being presented this cycle lands only at the register file's
  // sampling edge, so decode must still treat its targets as busy.
  logic out_hit1;
  logic out_hit2;

  assign out_hit1 = ((regwrite_reg != 2'd0) && (wreg1_reg == chk_reg1)) ||
                    ((regwrite_reg == 2'd2) && (wreg2_reg == chk_reg1));
  assign out_hit2 = ((regwrite_reg != 2'd0) && (wreg1_reg == chk_reg2)) ||
                    ((regwrite_reg == 2'd2) && (wreg2_reg == chk_reg2));

  assign chk_busy1 = (|hit1) || out_hit1;
  assign chk_busy2 = (|hit2) || out_hit2;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: a queue-of-structs reference model, a negedge
// compare process, directed scenarios with literal expectations, then a
// randomized phase.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_dual;
  logic [3:0]    in_reg1, in_reg2;
  logic [15:0]   in_data1, in_data2;
  logic          stall;
  logic [1:0]    RegWrite;
  logic [3:0]    WriteReg1, WriteReg2;
  logic [15:0]   WriteData1, WriteData2;
  logic [3:0]    chk_reg1, chk_reg2;
  logic          chk_busy1, chk_busy2;
  logic [CW-1:0] count;
  logic          empty, full;

  always #5 clock = ~clock;

  writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dual(in_dual),
    .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_data1(in_data1), .in_data2(in_data2),
    .stall(stall),
    .RegWrite(RegWrite), .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic        dual;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [15:0] d1;
    logic [15:0] d2;
  } ent_t;

  // Reference model: pending requests plus the expected write port.
  ent_t        q[$];
  logic [1:0]  m_rw;
  logic [3:0]  m_wr1, m_wr2;
  logic [15:0] m_wd1, m_wd2;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A register is busy if any pending request writes it, or if the write
  // currently on the port targets it.
  function automatic logic busy_model(input logic [3:0] r);
    logic b;
    b = 1'b0;
    foreach (q[i]) begin
      if (q[i].r1 == r || (q[i].dual && q[i].r2 == r)) b = 1'b1;
    end
    if (m_rw != 2'd0 && m_wr1 == r) b = 1'b1;
    if (m_rw == 2'd2 && m_wr2 == r) b = 1'b1;
    return b;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("RegWrite",   RegWrite,   m_rw);
      check("WriteReg1",  WriteReg1,  m_wr1);
      check("WriteReg2",  WriteReg2,  m_wr2);
      check("WriteData1", WriteData1, m_wd1);
      check("WriteData2", WriteData2, m_wd2);
      check("count",      count,      q.size());
      check("empty",      empty,      q.size() == 0);
      check("full",       full,       q.size() == DEPTH);
      check("in_ready",   in_ready,   q.size() < DEPTH);
      check("chk_busy1",  chk_busy1,  busy_model(chk_reg1));
      check("chk_busy2",  chk_busy2,  busy_model(chk_reg2));
    end
  end

  // One clock of stimulus; the model decides push/pop from pre-edge state.
  task automatic step(input logic rst, input logic v, input logic dl,
                      input logic [3:0] r1, input logic [3:0] r2,
                      input logic [15:0] d1, input logic [15:0] d2,
                      input logic st, input logic [3:0] c1, input logic [3:0] c2);
    bit   do_push, do_pop;
    ent_t e, h;
    reset = rst; in_valid = v; in_dual = dl;
    in_reg1 = r1; in_reg2 = r2; in_data1 = d1; in_data2 = d2;
    stall = st; chk_reg1 = c1; chk_reg2 = c2;
    do_push = !rst && v && (q.size() < DEPTH);
    do_pop  = !rst && !st && (q.size() > 0);
    e = '{dl, r1, r2, d1, d2};
    @(posedge clock);
    if (rst) begin
      q.delete();
      m_rw = 2'd0; m_wr1 = '0; m_wr2 = '0; m_wd1 = '0; m_wd2 = '0;
    end else begin
      if (do_pop) begin
        h = q.pop_front();
        if (h.dual && h.r1 != h.r2) m_rw = 2'd2;
        else m_rw = 2'd1;
        m_wr1 = h.r1;
        m_wd1 = (h.dual && h.r1 == h.r2) ? h.d2 : h.d1;
        m_wr2 = h.r2;
        m_wd2 = h.d2;
        $display("[TB] write rw=%0d r1=%0d d1=%h r2=%0d d2=%h", m_rw, m_wr1, m_wd1, m_wr2, m_wd2);
      end else begin
        m_rw = 2'd0;
      end
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0, st, chk_reg1, chk_reg2);
  endtask

  initial begin
    int stall_pct;

    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_rw",    RegWrite, 0);
    check("rst_wd1",   WriteData1, 0);

    // Single write, no bypass.
    step(0, 1, 0, 4'd5, 4'd0, 16'h1234, 16'h0, 0, 0, 0);
    check("single_nobypass_rw", RegWrite, 0);
    check("single_count", count, 1);
    idle(0);
    check("single_rw",  RegWrite, 1);
    check("single_wr1", WriteReg1, 5);
    check("single_wd1", WriteData1, 16'h1234);
    check("single_count0", count, 0);
    idle(0);
    check("single_rw_off", RegWrite, 0);
    check("single_wd1_hold", WriteData1, 16'h1234);

    // Dual write.
    step(0, 1, 1, 4'd0, 4'd1, 16'h0001, 16'hBEEF, 0, 0, 0);
    idle(0);
    check("dual_rw",  RegWrite, 2);
    check("dual_wr1", WriteReg1, 0);
    check("dual_wd1", WriteData1, 16'h0001);
    check("dual_wr2", WriteReg2, 1);
    check("dual_wd2", WriteData2, 16'hBEEF);
    idle(0);
    check("dual_rw_off", RegWrite, 0);

    // Fill under stall, held request, drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 0, 4'(i + 1), 4'd0, 16'hA000 + 16'(i), 16'h0, 1, 0, 0);
    check("fill_full", full, 1);
    check("fill_ready", in_ready, 0);
    check("fill_count", count, DEPTH);
    step(0, 1, 0, 4'hC, 4'd0, 16'hA00C, 16'h0, 1, 0, 0);
    check("held_count", count, DEPTH);
    step(0, 1, 0, 4'hC, 4'd0, 16'hA00C, 16'h0, 0, 0, 0);
    check("release_count", count, DEPTH - 1);
    check("release_wr1", WriteReg1, 1);
    check("release_wd1", WriteData1, 16'hA000);
    step(0, 1, 0, 4'hC, 4'd0, 16'hA00C, 16'h0, 0, 0, 0);
    check("accept_count", count, DEPTH - 1);
    check("accept_wr1", WriteReg1, 2);
    idle(0); idle(0); idle(0);
    check("drain_last_wr1", WriteReg1, 4'hC);
    check("drain_last_wd1", WriteData1, 16'hA00C);
    check("drain_count", count, 0);

    // Same-register dual collapses to a single write of data2.
    step(0, 1, 1, 4'd7, 4'd7, 16'h1111, 16'h2222, 0, 0, 0);
    idle(0);
    check("collapse_rw",  RegWrite, 1);
    check("collapse_wr1", WriteReg1, 7);
    check("collapse_wd1", WriteData1, 16'h2222);
    check("collapse_wd2", WriteData2, 16'h2222);

    // Scoreboard across queue residency and the output cycle.
    step(0, 1, 0, 4'd3, 4'd0, 16'h0333, 16'h0, 1, 4'd10, 4'd4);
    step(0, 1, 1, 4'd9, 4'd10, 16'h0999, 16'h0AAA, 1, 4'd10, 4'd4);
    check("sb_busy1_q", chk_busy1, 1);
    check("sb_busy2_q", chk_busy2, 0);
    idle(0);
    check("sb_busy1_r3out", chk_busy1, 1);
    idle(0);
    check("sb_rw_dual", RegWrite, 2);
    check("sb_busy1_out", chk_busy1, 1);
    idle(0);
    check("sb_busy1_done", chk_busy1, 0);

    // Reset with entries queued.
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 4'(i + 8), 4'd0, 16'hC000 + 16'(i), 16'h0, 1, 0, 0);
    check("pre_reset_count", count, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("midreset_count", count, 0);
    check("midreset_rw", RegWrite, 0);
    idle(0);
    check("postreset_rw1", RegWrite, 0);
    idle(0);
    check("postreset_rw2", RegWrite, 0);

    // Randomized phase with small register range to provoke collisions.
    stall_pct = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) stall_pct = (n / 200) % 3 == 0 ? 0 : ((n / 200) % 3 == 1 ? 25 : 70);
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1),
           4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
           16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < stall_pct),
           4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Buffers register-writeback requests from the execute stage and drains them, one request per cycle, into the 16x16 register file's write interface.
- Drives the register file's RegWrite/WriteReg1/WriteReg2/WriteData1/WriteData2 inputs. A RegWrite code of 2 means a dual write, used by MUL/DIV to deliver both result halves in one cycle.
- Provides two scoreboard lookup ports so decode can stall on pending writes to its source registers.

Parameters:
- DEPTH, 4, number of queued requests; power of two, 2..16.
- CW, 3, count width; must equal clog2(DEPTH+1).

Ports:
- clock  in  1  system clock; queue state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  writeback request present.
- in_ready  out  1  queue can accept; equals !full (combinational from state only).
- in_dual  in  1  request carries two writes.
- in_reg1  in  4  first destination register.
- in_reg2  in  4  second destination register (ignored when in_dual=0).
- in_data1  in  16  first write data.
- in_data2  in  16  second write data.
- stall  in  1  hold drain; no register-file write this cycle.
- RegWrite  out  2  0 = none, 1 = single write, 2 = dual write.
- WriteReg1, WriteReg2  out  4 each  destination registers.
- WriteData1, WriteData2  out  16 each  write data.
- chk_reg1, chk_reg2  in  4 each  decode source registers to test.
- chk_busy1, chk_busy2  out  1 each  pending write to chk_regN exists.
- count  out  CW  entries currently queued.
- empty, full  out  1 each  queue status.

Behaviour:
- Reset, sampled at posedge:
  - queue cleared; count=0, empty=1, full=0.
  - RegWrite=0; WriteReg1/2=0; WriteData1/2=0.
  - any push or pop in that cycle is discarded.
  - reset mid-drain loses all queued entries; this is intentional, as the pipeline flushes on reset.
- Push:
  - occurs at posedge when in_valid && in_ready && !reset.
  - stores {dual, reg1, reg2, data1, data2} at the tail.
  - in_valid while full is refused; the producer holds the request.
  - full blocks a push even if a pop happens in the same cycle.
- Pop:
  - occurs at posedge when !empty && !stall && !reset.
  - head fields load into the registered write outputs; RegWrite = dual ? 2 : 1 for exactly one cycle.
  - otherwise RegWrite=0 and the data/register outputs hold their previous values.
- Output timing: outputs are registered, so they are stable across the following negedge, where the register file samples them.
- Same-register collapse:
  - a dual entry with reg1==reg2 is emitted as RegWrite=1, WriteReg1=reg1, WriteData1=data2 (the second result wins).
  - WriteReg2 and WriteData2 still carry the entry's fields.
- Latency:
  - a request pushed at posedge N into an empty queue reaches the outputs at posedge N+1 at the earliest; there is no bypass path.
  - throughput is one request per cycle.
- Simultaneous push and pop (not full): both occur; count is unchanged; FIFO order is preserved.
- Pointers: read and write pointers wrap modulo DEPTH. count is tracked explicitly, so full/empty are unambiguous at wrap.
- Scoreboard (combinational):
  - chk_busyN=1 if any valid queue entry targets chk_regN via reg1, or via reg2 when dual.
  - chk_busyN is also 1 if the current output cycle has RegWrite!=0 and WriteReg1 (or WriteReg2 when RegWrite=2) equals chk_regN.
  - register 0 is not special; it is checked like any other register.
- Outputs never carry X after the first reset cycle.

Test Plan:
- Reset, then push single {r5, 0x1234} with stall=0 -> one cycle later RegWrite=1, WriteReg1=5, WriteData1=0x1234; next cycle RegWrite=0; count back to 0.
- Push dual {r0=0x0001, r1=0xBEEF} -> RegWrite=2, WriteReg1=0, WriteData1=0x0001, WriteReg2=1, WriteData2=0xBEEF for exactly one cycle.
- stall=1, push DEPTH entries -> full=1, in_ready=0, 5th push held. Release stall -> entries drain in order, one per cycle; the held request is accepted on the first cycle count<DEPTH.
- Dual with reg1=reg2=7, data 0x1111/0x2222 -> RegWrite=1, WriteReg1=7, WriteData1=0x2222.
- Queue {r3, r9-dual-r10}, chk_reg1=10, chk_reg2=4 -> chk_busy1=1, chk_busy2=0. After the r9/r10 entry's output cycle ends -> chk_busy1=0.
- Assert reset with 3 entries queued and stall=0 -> next cycle count=0, RegWrite=0, no further writes emitted.
